// File: rtl/fft_ram_seq.sv
// rtl/fft_ram_seq.sv - radix-2 DIF FFT address/stage sequencer for the ping-pong ram_block
// Optional: define FFT_SEQ_BITREV_OUT_EN to bit-reverse final-stage write addresses (natural-order output).
module fft_ram_seq #(
    parameter int size   = 1024,
    parameter int log_s  = 10,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [log_s-1:0] stage,
    output logic [log_s-1:0] rd_addr_0,
    output logic [log_s-1:0] rd_addr_1,
    output logic [log_s-1:0] wr_addr_0,
    output logic [log_s-1:0] wr_addr_1,
    output logic             wr_en,
    output logic             ram_select,
    output logic [log_s-2:0] tw_idx
);
    localparam int PIPE_LAT  = RD_LAT + BF_LAT;
    localparam int HALF_N    = size / 2;
    localparam int STAGE_LEN = HALF_N + PIPE_LAT;
    localparam int CW        = $clog2(STAGE_LEN + 1);
    localparam logic [CW-1:0]    C_LAST = CW'(STAGE_LEN - 1);
    localparam logic [CW-1:0]    C_HM1  = CW'(HALF_N - 1);
    localparam logic [log_s-1:0] S_LAST = log_s'(log_s - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    typedef struct packed {
        logic [log_s-1:0] a0;
        logic [log_s-1:0] a1;
        logic [log_s-2:0] tw;
    } rd_t;

    // Butterfly k of stage st: insert a zero bit at position log2(half) of k.
    function automatic rd_t addr_of(input logic [log_s-1:0] k, input logic [log_s-1:0] st);
        logic [log_s-1:0] half;
        logic [log_s-1:0] mask;
        logic [log_s-1:0] lo;
        rd_t r;
        half = log_s'(size >> (st + 1));
        mask = half - 1'b1;
        lo   = k & mask;
        r.a0 = ((k & ~mask) << 1) | lo;
        r.a1 = r.a0 | half;
        r.tw = (log_s-1)'(lo << st);
        return r;
    endfunction

    state_t        state;
    logic [CW-1:0] c;
    logic          rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            c          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stage      <= '0;
            ram_select <= 1'b0;
            rd_valid   <= 1'b0;
            {rd_addr_0, rd_addr_1, tw_idx} <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        c        <= '0;
                        stage    <= '0;
                        rd_valid <= 1'b1;
                        {rd_addr_0, rd_addr_1, tw_idx} <= addr_of('0, '0);
                    end
                end
                RUN: begin
                    if (c == C_LAST) begin
                        c          <= '0;
                        ram_select <= ~ram_select;
                        if (stage == S_LAST) begin
                            state    <= LAST;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            stage    <= '0;
                            rd_valid <= 1'b0;
                        end else begin
                            stage    <= stage + 1'b1;
                            rd_valid <= 1'b1;
                            {rd_addr_0, rd_addr_1, tw_idx} <= addr_of('0, stage + 1'b1);
                        end
                    end else begin
                        c <= c + 1'b1;
                        if (c < C_HM1) begin
                            rd_valid <= 1'b1;
                            {rd_addr_0, rd_addr_1, tw_idx} <= addr_of(log_s'(c + 1'b1), stage);
                        end else begin
                            rd_valid <= 1'b0;
                        end
                    end
                end
                LAST: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic             d_v;
    logic [log_s-1:0] d_a0;
    logic [log_s-1:0] d_a1;

    generate
        if (PIPE_LAT == 0) begin : g_nodelay
            assign d_v  = rd_valid;
            assign d_a0 = rd_addr_0;
            assign d_a1 = rd_addr_1;
        end else begin : g_delay
            logic [PIPE_LAT-1:0] dv;
            logic [log_s-1:0]    da0 [PIPE_LAT];
            logic [log_s-1:0]    da1 [PIPE_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    dv <= '0;
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        da0[i] <= '0;
                        da1[i] <= '0;
                    end
                end else begin
                    dv[0]  <= rd_valid;
                    da0[0] <= rd_addr_0;
                    da1[0] <= rd_addr_1;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        dv[i]  <= dv[i-1];
                        da0[i] <= da0[i-1];
                        da1[i] <= da1[i-1];
                    end
                end
            end
            assign d_v  = dv[PIPE_LAT-1];
            assign d_a0 = da0[PIPE_LAT-1];
            assign d_a1 = da1[PIPE_LAT-1];
        end
    endgenerate

    assign wr_en = d_v;

`ifdef FFT_SEQ_BITREV_OUT_EN
    function automatic logic [log_s-1:0] bitrev(input logic [log_s-1:0] a);
        logic [log_s-1:0] r;
        for (int i = 0; i < log_s; i++) r[i] = a[log_s-1-i];
        return r;
    endfunction

    // Writes of a stage never straddle a stage boundary, so the live stage index applies.
    assign wr_addr_0 = (stage == S_LAST) ? bitrev(d_a0) : d_a0;
    assign wr_addr_1 = (stage == S_LAST) ? bitrev(d_a1) : d_a1;
`else
    assign wr_addr_0 = d_a0;
    assign wr_addr_1 = d_a1;
`endif
endmodule

// File: tb/tb_fft_ram_seq.sv
// tb/tb_fft_ram_seq.sv - directed self-checking bench for fft_ram_seq (size=8, RD_LAT=1, BF_LAT=2)
module tb_fft_ram_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic [2:0] rd_addr_0;
    logic [2:0] rd_addr_1;
    logic [2:0] wr_addr_0;
    logic [2:0] wr_addr_1;
    logic       wr_en;
    logic       ram_select;
    logic [1:0] tw_idx;

    int checks = 0;
    int errors = 0;

    int e_rd0  [3][4] = '{'{0, 1, 2, 3}, '{0, 1, 4, 5}, '{0, 2, 4, 6}};
    int e_tw   [3][4] = '{'{0, 1, 2, 3}, '{0, 2, 0, 2}, '{0, 0, 0, 0}};
    int e_half [3]    = '{4, 2, 1};

    fft_ram_seq #(.size(8), .log_s(3), .RD_LAT(1), .BF_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .wr_addr_0(wr_addr_0),
        .wr_addr_1(wr_addr_1), .wr_en(wr_en), .ram_select(ram_select), .tw_idx(tw_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rev3(input int a);
        return ((a & 1) << 2) | (a & 2) | ((a >> 2) & 1);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " stage"}, 32'(stage), 0);
        chk({tag, " rd0"}, 32'(rd_addr_0), 0);
        chk({tag, " rd1"}, 32'(rd_addr_1), 0);
        chk({tag, " wr0"}, 32'(wr_addr_0), 0);
        chk({tag, " wr1"}, 32'(wr_addr_1), 0);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " ram_select"}, 32'(ram_select), 0);
        chk({tag, " tw"}, 32'(tw_idx), 0);
    endtask

    // Called in the first cycle with busy high; returns in the done cycle.
    task automatic run_check(input int r0, input int poke);
        int s, c, w0, w1;
        for (int t = 0; t < 21; t++) begin
            s = t / 7;
            c = t % 7;
            chk($sformatf("busy t%0d", t), 32'(busy), 1);
            chk($sformatf("done t%0d", t), 32'(done), 0);
            chk($sformatf("stage t%0d", t), 32'(stage), 32'(s));
            chk($sformatf("ram_select t%0d", t), 32'(ram_select), 32'((r0 ^ s) & 1));
            if (c < 4) begin
                chk($sformatf("rd0 s%0d k%0d", s, c), 32'(rd_addr_0), 32'(e_rd0[s][c]));
                chk($sformatf("rd1 s%0d k%0d", s, c), 32'(rd_addr_1), 32'(e_rd0[s][c] + e_half[s]));
                chk($sformatf("tw s%0d k%0d", s, c), 32'(tw_idx), 32'(e_tw[s][c]));
            end
            chk($sformatf("wr_en t%0d", t), 32'(wr_en), (c >= 3) ? 1 : 0);
            if (c >= 3) begin
                w0 = e_rd0[s][c-3];
                w1 = w0 + e_half[s];
`ifdef FFT_SEQ_BITREV_OUT_EN
                if (s == 2) begin
                    w0 = rev3(w0);
                    w1 = rev3(w1);
                end
`endif
                chk($sformatf("wr0 s%0d k%0d", s, c - 3), 32'(wr_addr_0), 32'(w0));
                chk($sformatf("wr1 s%0d k%0d", s, c - 3), 32'(wr_addr_1), 32'(w1));
            end
            if (poke >= 0 && t == poke) start = 1'b1;
            else if (poke >= 0 && t == poke + 1) start = 1'b0;
            step();
        end
        chk("done pulse", 32'(done), 1);
        chk("busy at done", 32'(busy), 0);
        chk("wr_en at done", 32'(wr_en), 0);
        chk("stage at done", 32'(stage), 0);
        chk("ram_select after run", 32'(ram_select), 32'((r0 ^ 1) & 1));
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle busy %0d", i), 32'(busy), 0);
            chk($sformatf("idle wr_en %0d", i), 32'(wr_en), 0);
        end

        start = 1'b1;
        step();
        start = 1'b0;
        run_check(0, -1);
        step();
        chk("idle after run busy", 32'(busy), 0);
        chk("idle after run done", 32'(done), 0);
        chk("idle after run wr_en", 32'(wr_en), 0);

        start = 1'b1;
        step();
        start = 1'b0;
        run_check(1, 5);

        step();
        start = 1'b1;
        step();
        run_check(0, -1);
        step();
        chk("held start idle busy", 32'(busy), 0);
        chk("held start idle done", 32'(done), 0);
        step();
        chk("held start restart busy", 32'(busy), 1);
        chk("held start restart stage", 32'(stage), 0);
        chk("held start restart rd1", 32'(rd_addr_1), 4);
        chk("held start restart wr_en", 32'(wr_en), 0);
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("pre-reset stage", 32'(stage), 1);
        chk("pre-reset rd0", 32'(rd_addr_0), 4);
        chk("pre-reset rd1", 32'(rd_addr_1), 6);
        chk("pre-reset ram_select", 32'(ram_select), 0);
        rst = 1'b1;
        step();
        chk_zero("mid-run reset");
        rst = 1'b0;
        step();
        chk("post-reset wr_en", 32'(wr_en), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_check(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
